// File: rtl/psum_multi_write_controller.sv
// Drains psum batches from the source FIFO into NUM_CH buffers (sequential or broadcast), queuing one start.
// First write can land 1 cycle after done; a word moves only when valid and the selected ready(s) are high, else stall.
module psum_multi_write_controller #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done,
   input  logic [CNT_W-1:0]  psum_len,
   input  logic              mode,
   input  logic              valid,
   input  logic [NUM_CH-1:0] ready,
   output logic              ren,
   output logic [NUM_CH-1:0] wen,
   output logic              stall,
   output logic              busy,
   output logic [CH_W-1:0]   ch_sel,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              batch_done,
   output logic              overrun
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WRITE  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             mode_q, mode_d;
   logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] sh_len_q, sh_len_d;
   logic             sh_mode_q, sh_mode_d;

   logic sel_rdy, xfer, last_word, last_ch;

   assign sel_rdy   = mode_q ? (&ready) : ready[ch_sel_q];
   assign xfer      = (state_q == S_WRITE) && valid && sel_rdy;
   assign last_word = (word_cnt_q == (len_q - CNT_W'(1)));
   assign last_ch   = (ch_sel_q == CH_W'(NUM_CH - 1));

   assign ch_sel   = ch_sel_q;
   assign word_cnt = word_cnt_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      mode_d     = mode_q;
      ch_sel_d   = ch_sel_q;
      word_cnt_d = word_cnt_q;
      pend_d     = pend_q;
      sh_len_d   = sh_len_q;
      sh_mode_d  = sh_mode_q;
      ren        = 1'b0;
      wen        = '0;
      stall      = 1'b0;
      busy       = 1'b0;
      batch_done = 1'b0;
      overrun    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (done) begin
               len_d      = psum_len;
               mode_d     = mode;
               word_cnt_d = '0;
               ch_sel_d   = '0;
               state_d    = (psum_len == '0) ? S_FINISH : S_WRITE;
            end
         end

         S_WRITE: begin
            busy  = 1'b1;
            ren   = xfer;
            stall = !xfer;
            if (xfer) begin
               wen = mode_q ? {NUM_CH{1'b1}} : (NUM_CH'(1) << ch_sel_q);
               if (last_word) begin
                  word_cnt_d = '0;
                  if (mode_q || last_ch) begin
                     state_d  = S_FINISH;
                     ch_sel_d = '0;
                  end else begin
                     ch_sel_d = ch_sel_q + CH_W'(1);
                  end
               end else begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
            end
            // Only one request can wait behind the running batch.
            if (done) begin
               if (pend_q) begin
                  overrun = 1'b1;
               end else begin
                  pend_d    = 1'b1;
                  sh_len_d  = psum_len;
                  sh_mode_d = mode;
               end
            end
         end

         S_FINISH: begin
            busy       = 1'b1;
            stall      = 1'b1;
            batch_done = 1'b1;
            overrun    = done && pend_q;
            word_cnt_d = '0;
            ch_sel_d   = '0;
            if (pend_q) begin
               len_d   = sh_len_q;
               mode_d  = sh_mode_q;
               pend_d  = 1'b0;
               state_d = (sh_len_q == '0) ? S_FINISH : S_WRITE;
            end else if (done) begin
               len_d   = psum_len;
               mode_d  = mode;
               state_d = (psum_len == '0) ? S_FINISH : S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         mode_q     <= 1'b0;
         ch_sel_q   <= '0;
         word_cnt_q <= '0;
         pend_q     <= 1'b0;
         sh_len_q   <= '0;
         sh_mode_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         mode_q     <= mode_d;
         ch_sel_q   <= ch_sel_d;
         word_cnt_q <= word_cnt_d;
         pend_q     <= pend_d;
         sh_len_q   <= sh_len_d;
         sh_mode_q  <= sh_mode_d;
      end
   end

endmodule
